// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: baud_select encodings, 16x tick divider math,
// receiver FSM states and frame-format defaults.
package uart_receiver_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS_DEFAULT  = 8;
  localparam int unsigned CLK_HZ_DEFAULT     = 50_000_000;

  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    int unsigned rate;
    rate = 300;
    case (sel)
      BAUD_300:    rate = 300;
      BAUD_1200:   rate = 1200;
      BAUD_4800:   rate = 4800;
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      BAUD_115200: rate = 115200;
      default:     rate = 300;
    endcase
    return rate;
  endfunction

  // Clocks between sample ticks; never below 1 so a fast rate on a slow
  // clock degrades to a tick every cycle instead of stalling.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned oversample,
                                           input logic [2:0]  sel);
    int unsigned div;
    div = clk_hz / (oversample * baud_rate(sel));
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_receiver_baud.sv
// baud_controller: emits a one-clk sample tick at OVERSAMPLE x the rate
// chosen by baud_select. Shared with the transmitter side.
module baud_controller
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_enable
);

  logic [23:0] div_cnt;
  logic [23:0] div_last;

  assign div_last = 24'(baud_div(CLK_HZ, OVERSAMPLE, baud_select) - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt       <= '0;
      sample_enable <= 1'b0;
    end else if (div_cnt >= div_last) begin
      // >= rather than == so a rate change to a shorter period cannot
      // leave the counter stranded above the new terminal count.
      div_cnt       <= '0;
      sample_enable <= 1'b1;
    end else begin
      div_cnt       <= div_cnt + 24'd1;
      sample_enable <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, sampled
// mid-bit from a 16x oversampled, synchronized RxD.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 sample_enable;
  logic                 sync_q1;
  logic                 rxd_s;
  rx_state_t            state;
  logic                 armed;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_acc;

  baud_controller #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .sample_enable (sample_enable)
  );

  // NOTE: non-blocking assignments make the two flops a real 2-stage chain;
  // blocking ones would collapse it into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      sync_q1 <= RxD;
      rxd_s   <= sync_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_acc <= 1'b0;
      Rx_DATA    <= '0;
      Rx_VALID   <= 1'b0;
      Rx_PERROR  <= 1'b0;
      Rx_FERROR  <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      if (!Rx_EN) begin
        state    <= IDLE;
        armed    <= 1'b0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (sample_enable) begin
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + TW'(1);
        unique case (state)
          IDLE: begin
            tick_cnt <= '0;
            // Arming on a high line keeps a stuck-low RxD from retriggering.
            if (!armed)      armed <= rxd_s;
            else if (!rxd_s) state <= START;
          end
          START: begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              if (!rxd_s) begin
                state      <= DATA;
                bit_cnt    <= '0;
                parity_acc <= 1'b0;
                Rx_PERROR  <= 1'b0;
                Rx_FERROR  <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              shift_reg  <= {rxd_s, shift_reg[DATA_BITS-1:1]};
              parity_acc <= parity_acc ^ rxd_s;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= PARITY;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          PARITY: begin
            if (tick_cnt == LAST_TICK) begin
              Rx_PERROR <= (rxd_s != parity_acc);
              state     <= STOP;
            end
          end
          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              Rx_DATA   <= shift_reg;
              Rx_FERROR <= ~rxd_s;
              Rx_VALID  <= rxd_s & ~Rx_PERROR;
              armed     <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: the bench drives RxD as the transmitter
// would and checks data, valid pulses and error flags per scenario.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  // 3.6864 MHz clock: 16x divider is 2 at 115200 baud and 24 at 9600 baud.
  localparam int unsigned CLK_HZ = 3_686_400;
  localparam int BIT_FAST = 32;
  localparam int BIT_SLOW = 384;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = BAUD_115200;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int checks = 0;
  int passed = 0;
  int valid_cnt = 0;
  logic [7:0] valid_q[$];

  uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Rx_VALID === 1'b1) begin
      valid_cnt++;
      valid_q.push_back(Rx_DATA);
    end
  end

  task automatic drive_bit(input logic v, input int bit_clks);
    RxD = v;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic idle_bits(input int n, input int bit_clks);
    drive_bit(1'b1, n * bit_clks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop, input int bit_clks);
    drive_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_clks);
    drive_bit((^d) ^ bad_par, bit_clks);
    drive_bit(stop, bit_clks);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++; if (Rx_DATA !== 8'h00) $display("FAIL reset_data: got %h expected 00", Rx_DATA); else passed++;
    checks++; if (Rx_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Rx_VALID); else passed++;
    checks++; if (Rx_PERROR !== 1'b0) $display("FAIL reset_perror: got %b expected 0", Rx_PERROR); else passed++;
    checks++; if (Rx_FERROR !== 1'b0) $display("FAIL reset_ferror: got %b expected 0", Rx_FERROR); else passed++;
    reset = 1'b0;
    idle_bits(2, BIT_FAST);
  endtask

  task automatic test_loopback();
    int base;
    baud_select = BAUD_9600;
    idle_bits(2, BIT_SLOW);
    base = valid_cnt;
    valid_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1, BIT_SLOW);
    idle_bits(1, BIT_SLOW);
    checks++; if (valid_cnt - base !== 1) $display("FAIL loopback_valid_count: got %0d expected 1", valid_cnt - base); else passed++;
    checks++; if (Rx_DATA !== 8'hA5) $display("FAIL loopback_data: got %h expected a5", Rx_DATA); else passed++;
    checks++; if ((valid_q.size() > 0 ? valid_q[0] : 8'hxx) !== 8'hA5) $display("FAIL loopback_valid_data: got %h expected a5", valid_q.size() > 0 ? valid_q[0] : 8'hxx); else passed++;
    checks++; if (Rx_PERROR !== 1'b0) $display("FAIL loopback_perror: got %b expected 0", Rx_PERROR); else passed++;
    checks++; if (Rx_FERROR !== 1'b0) $display("FAIL loopback_ferror: got %b expected 0", Rx_FERROR); else passed++;
    baud_select = BAUD_115200;
    idle_bits(2, BIT_FAST);
  endtask

  task automatic test_parity_error();
    int base;
    base = valid_cnt;
    send_frame(8'h01, 1'b1, 1'b1, BIT_FAST);
    idle_bits(2, BIT_FAST);
    checks++; if (Rx_DATA !== 8'h01) $display("FAIL parity_data: got %h expected 01", Rx_DATA); else passed++;
    checks++; if (Rx_PERROR !== 1'b1) $display("FAIL parity_perror: got %b expected 1", Rx_PERROR); else passed++;
    checks++; if (Rx_FERROR !== 1'b0) $display("FAIL parity_ferror: got %b expected 0", Rx_FERROR); else passed++;
    checks++; if (valid_cnt - base !== 0) $display("FAIL parity_no_valid: got %0d expected 0", valid_cnt - base); else passed++;
  endtask

  task automatic test_start_glitch();
    int base;
    base = valid_cnt;
    drive_bit(1'b0, 8);  // 4 sample ticks at divider 2
    idle_bits(12, BIT_FAST);
    checks++; if (valid_cnt - base !== 0) $display("FAIL glitch_no_valid: got %0d expected 0", valid_cnt - base); else passed++;
    checks++; if (Rx_PERROR !== 1'b1) $display("FAIL glitch_perror_held: got %b expected 1", Rx_PERROR); else passed++;
    checks++; if (Rx_DATA !== 8'h01) $display("FAIL glitch_data_held: got %h expected 01", Rx_DATA); else passed++;
  endtask

  task automatic test_framing_error();
    int base;
    base = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, BIT_FAST);
    drive_bit(1'b0, 12 * BIT_FAST);
    checks++; if (Rx_FERROR !== 1'b1) $display("FAIL framing_ferror: got %b expected 1", Rx_FERROR); else passed++;
    checks++; if (Rx_PERROR !== 1'b0) $display("FAIL framing_perror: got %b expected 0", Rx_PERROR); else passed++;
    checks++; if (Rx_DATA !== 8'h3C) $display("FAIL framing_data_no_retrigger: got %h expected 3c", Rx_DATA); else passed++;
    checks++; if (valid_cnt - base !== 0) $display("FAIL framing_no_valid: got %0d expected 0", valid_cnt - base); else passed++;
    idle_bits(2, BIT_FAST);
    send_frame(8'h5A, 1'b0, 1'b1, BIT_FAST);
    idle_bits(1, BIT_FAST);
    checks++; if (valid_cnt - base !== 1) $display("FAIL framing_recover_valid: got %0d expected 1", valid_cnt - base); else passed++;
    checks++; if (Rx_DATA !== 8'h5A) $display("FAIL framing_recover_data: got %h expected 5a", Rx_DATA); else passed++;
    checks++; if (Rx_FERROR !== 1'b0) $display("FAIL framing_recover_ferror: got %b expected 0", Rx_FERROR); else passed++;
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] exp_bytes [3];
    exp_bytes = '{8'h00, 8'hFF, 8'h55};
    base = valid_cnt;
    valid_q.delete();
    for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b0, 1'b1, BIT_FAST);
    idle_bits(1, BIT_FAST);
    checks++; if (valid_cnt - base !== 3) $display("FAIL b2b_valid_count: got %0d expected 3", valid_cnt - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ((valid_q.size() > i ? valid_q[i] : 8'hxx) !== exp_bytes[i])
        $display("FAIL b2b_data_%0d: got %h expected %h", i, valid_q.size() > i ? valid_q[i] : 8'hxx, exp_bytes[i]);
      else passed++;
    end
  endtask

  task automatic test_abort_reset();
    int base;
    logic [7:0] d;
    d = 8'h81;
    base = valid_cnt;
    drive_bit(1'b0, BIT_FAST);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_FAST);
    drive_bit(d[4], BIT_FAST / 2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    RxD = 1'b1;
    @(negedge clk);
    checks++; if (Rx_DATA !== 8'h00) $display("FAIL abort_reset_data: got %h expected 00", Rx_DATA); else passed++;
    checks++; if (Rx_PERROR !== 1'b0) $display("FAIL abort_reset_perror: got %b expected 0", Rx_PERROR); else passed++;
    idle_bits(12, BIT_FAST);
    checks++; if (valid_cnt - base !== 0) $display("FAIL abort_reset_no_valid: got %0d expected 0", valid_cnt - base); else passed++;
    send_frame(8'h7E, 1'b0, 1'b1, BIT_FAST);
    idle_bits(1, BIT_FAST);
    checks++; if (valid_cnt - base !== 1) $display("FAIL abort_reset_next_valid: got %0d expected 1", valid_cnt - base); else passed++;
    checks++; if (Rx_DATA !== 8'h7E) $display("FAIL abort_reset_next_data: got %h expected 7e", Rx_DATA); else passed++;
  endtask

  task automatic test_abort_enable();
    int base;
    logic [7:0] d;
    d = 8'h81;
    base = valid_cnt;
    drive_bit(1'b0, BIT_FAST);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_FAST);
    drive_bit(d[4], BIT_FAST / 2);
    Rx_EN = 1'b0;
    drive_bit(d[4], BIT_FAST / 2);
    for (int i = 5; i < 8; i++) drive_bit(d[i], BIT_FAST);
    drive_bit(^d, BIT_FAST);
    drive_bit(1'b1, BIT_FAST);
    idle_bits(2, BIT_FAST);
    checks++; if (valid_cnt - base !== 0) $display("FAIL abort_en_no_valid: got %0d expected 0", valid_cnt - base); else passed++;
    checks++; if (Rx_DATA !== 8'h7E) $display("FAIL abort_en_data_held: got %h expected 7e", Rx_DATA); else passed++;
    Rx_EN = 1'b1;
    idle_bits(1, BIT_FAST);
    send_frame(8'h7E, 1'b0, 1'b1, BIT_FAST);
    idle_bits(1, BIT_FAST);
    checks++; if (valid_cnt - base !== 1) $display("FAIL abort_en_next_valid: got %0d expected 1", valid_cnt - base); else passed++;
    checks++; if (Rx_DATA !== 8'h7E) $display("FAIL abort_en_next_data: got %h expected 7e", Rx_DATA); else passed++;
    checks++; if (Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) $display("FAIL abort_en_next_flags: got %b%b expected 00", Rx_PERROR, Rx_FERROR); else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_parity_error();
    test_start_glitch();
    test_framing_error();
    test_back_to_back();
    test_abort_reset();
    test_abort_enable();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
